// File: rtl/value_ram_ctrl_if.sv
// Bus bundle for value_ram_ctrl: tokenizer write side, consumer read side and RAM ports.
interface value_ram_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned NUM_REQ    = 2
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic                          wr_valid_i;
  logic [DATA_WIDTH-1:0]         wr_data_i;
  logic                          wr_ready_o;
  logic                          msg_end_i;
  logic                          msg_release_i;
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          rsp_valid_o;
  logic [IDW-1:0]                rsp_id_o;
  logic [DATA_WIDTH-1:0]         rsp_data_o;
  logic                          rsp_err_o;
  logic [ADDR_WIDTH:0]           count_o;
  logic                          full_o;
  logic                          overflow_o;
  logic                          ram_we_o;
  logic [ADDR_WIDTH-1:0]         ram_waddr_o;
  logic [DATA_WIDTH-1:0]         ram_wdata_o;
  logic                          ram_oe_o;
  logic [ADDR_WIDTH-1:0]         ram_raddr_o;
  logic                          ram_rvalid_i;
  logic [DATA_WIDTH-1:0]         ram_rdata_i;

  modport slave (
    input  wr_valid_i, wr_data_i, msg_end_i, msg_release_i, req_valid_i, req_addr_i,
           ram_rvalid_i, ram_rdata_i,
    output wr_ready_o, req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o,
           count_o, full_o, overflow_o, ram_we_o, ram_waddr_o, ram_wdata_o,
           ram_oe_o, ram_raddr_o
  );

  modport master (
    output wr_valid_i, wr_data_i, msg_end_i, msg_release_i, req_valid_i, req_addr_i,
           ram_rvalid_i, ram_rdata_i,
    input  wr_ready_o, req_ready_o, rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o,
           count_o, full_o, overflow_o, ram_we_o, ram_waddr_o, ram_wdata_o,
           ram_oe_o, ram_raddr_o
  );
endinterface

// File: rtl/value_ram_ctrl.sv
// Fill/read/drain sequencer and round-robin read arbiter for the parser value store.
// Optional bounds checking of read addresses: define VALUE_RAM_CTRL_BOUNDS_CHECK_EN.
module value_ram_ctrl #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned NUM_REQ    = 2
) (
  input logic             clk,
  input logic             rst,
  value_ram_ctrl_if.slave bus
);
  localparam int unsigned         IDW       = $clog2(NUM_REQ);
  localparam int unsigned         RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [IDW-1:0]      LAST_ID   = IDW'(NUM_REQ - 1);

  typedef enum logic [1:0] {FILL, READ, DRAIN} state_t;

  state_t              state;
  logic [ADDR_WIDTH:0] count;
  logic                full;
  logic                overflow;
  logic [IDW-1:0]      rr_ptr;

  logic                s1_valid;
  logic                s1_err;
  logic [IDW-1:0]      s1_id;
  logic                s2_valid;

  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  logic                  wr_ready;
  logic                  wr_en;
  logic                  gnt_en;
  logic                  gnt_any;
  logic [IDW-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]    gnt_vec;
  logic [ADDR_WIDTH-1:0] gnt_addr;
  logic                  rd_ok;

  assign wr_ready = !rst && (state == FILL) && !full;
  assign wr_en    = bus.wr_valid_i && wr_ready;
  assign gnt_en   = !rst && (state == READ) && !bus.msg_release_i;

  // Search starts at rr_ptr and wraps; first valid requester wins.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] cand;
    idx     = 0;
    cand    = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx  = (32'(rr_ptr) + i) % NUM_REQ;
      cand = IDW'(idx);
      if (gnt_en && !gnt_any && bus.req_valid_i[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  assign gnt_addr = bus.req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];

`ifdef VALUE_RAM_CTRL_BOUNDS_CHECK_EN
  assign rd_ok = ({1'b0, gnt_addr} < count);
`else
  assign rd_ok = 1'b1;
`endif

  assign bus.wr_ready_o  = wr_ready;
  assign bus.req_ready_o = gnt_vec;
  assign bus.ram_we_o    = wr_en;
  assign bus.ram_waddr_o = count[ADDR_WIDTH-1:0];
  assign bus.ram_wdata_o = bus.wr_data_i;
  assign bus.ram_oe_o    = gnt_any && rd_ok;
  assign bus.ram_raddr_o = gnt_addr;
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_id_o    = rsp_id;
  assign bus.rsp_data_o  = rsp_data;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.count_o     = count;
  assign bus.full_o      = full;
  assign bus.overflow_o  = overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      count     <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      rr_ptr    <= '0;
      s1_valid  <= 1'b0;
      s1_err    <= 1'b0;
      s1_id     <= '0;
      s2_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      s1_valid <= gnt_any;
      s1_err   <= gnt_any && !rd_ok;
      s1_id    <= gnt_idx;
      s2_valid <= s1_valid;

      // Out-of-range grants bypass the RAM and return a zeroed error response.
      rsp_valid <= s1_valid && (s1_err || bus.ram_rvalid_i);
      if (s1_valid && s1_err) begin
        rsp_id   <= s1_id;
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end else if (s1_valid && bus.ram_rvalid_i) begin
        rsp_id   <= s1_id;
        rsp_data <= bus.ram_rdata_i;
        rsp_err  <= 1'b0;
      end

      if (gnt_any) rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;

      case (state)
        FILL: begin
          if (bus.msg_release_i) begin
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
          end else begin
            if (wr_en) begin
              count <= count + 1'b1;
              full  <= ((count + 1'b1) == DEPTH_CNT);
            end
            if (bus.wr_valid_i && full) overflow <= 1'b1;
            if (bus.msg_end_i) state <= READ;
          end
        end
        READ: begin
          if (bus.msg_release_i) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            state    <= FILL;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/value_ram_ctrl.md
# value_ram_ctrl

Sequencer and read arbiter for the parser's 32 x 256-bit value store. It accepts FIX field values from the tokenizer and writes them to consecutive RAM locations. It freezes the store at end of message and shares the single RAM read port among NUM_REQ downstream consumers using round-robin arbitration. It clears the store when the consumers release the message.

## Interface
- ADDR_WIDTH, 5, RAM address width; RAM_DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 256, value width
- NUM_REQ, 2, number of read requesters (>= 2); IDW = $clog2(NUM_REQ)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_valid_i  in  1  tokenizer presents a value
- wr_data_i  in  DATA_WIDTH  value
- wr_ready_o  out  1  value accepted when wr_valid_i & wr_ready_o
- msg_end_i  in  1  single-cycle pulse, message complete
- msg_release_i  in  1  single-cycle pulse, consumers done, clear store
- req_valid_i  in  NUM_REQ  per-requester read request
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  per-requester address; slice i is requester i
- req_ready_o  out  NUM_REQ  one-hot grant, combinational
- rsp_valid_o  out  1  read response valid, registered
- rsp_id_o  out  IDW  requester index of the response
- rsp_data_o  out  DATA_WIDTH  read data
- rsp_err_o  out  1  out-of-range read (see Configuration)
- count_o  out  ADDR_WIDTH+1  number of stored values
- full_o  out  1  count_o == RAM_DEPTH
- overflow_o  out  1  sticky: a write was refused because the store was full
- ram_we_o, ram_waddr_o, ram_wdata_o  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port
- ram_oe_o, ram_raddr_o  out  1/ADDR_WIDTH  RAM read port
- ram_rvalid_i, ram_rdata_i  in  1/DATA_WIDTH  RAM read return, exactly 1 cycle after ram_oe_o

## Operation
- States: FILL, READ, DRAIN. Reset state is FILL.
- FILL
  - wr_ready_o = !full_o.
  - On an accepted write: ram_we_o=1, ram_waddr_o=count_o[ADDR_WIDTH-1:0], ram_wdata_o=wr_data_i, all combinational in the same cycle. count_o increments on the next edge.
  - wr_valid_i while full: the write is dropped and overflow_o is set.
  - msg_end_i moves the block to READ. A write in the same cycle is accepted first.
  - msg_release_i in FILL aborts the message: count and overflow are cleared and the block stays in FILL. If msg_end_i and msg_release_i arrive together, release wins.
  - req_ready_o = 0.
- READ
  - wr_ready_o = 0. msg_end_i is ignored.
  - Arbiter: round-robin over req_valid_i, starting search at rr_ptr.
  - Grant means req_ready_o[k]=1, ram_oe_o=1, ram_raddr_o=addr slice k.
  - After a grant, rr_ptr becomes k+1 mod NUM_REQ. rr_ptr is unchanged in cycles with no grant.
  - At most one grant per cycle; a new grant is allowed every cycle.
  - msg_release_i moves the block to DRAIN. No grant is made in the release cycle.
- DRAIN
  - No grants and no writes.
  - Stays until the response pipeline is empty (no grant in the previous 2 cycles), then goes to FILL with count_o=0 and overflow_o=0.
- Response path
  - The requester id is registered alongside the RAM access.
  - On ram_rvalid_i, rsp_valid_o/rsp_id_o/rsp_data_o are registered.
  - Consumers cannot stall responses; every requester must accept rsp_valid_o unconditionally.
- Reset values
  - State FILL, count 0, rr_ptr 0, overflow 0.
  - All handshake outputs 0, rsp_data_o 0, rsp_err_o 0, pipeline empty.
  - Reset mid-read discards any in-flight response.

## Timing
- Write: accepted in cycle N, RAM written at edge N+1, count_o updated at N+1.
- Read: handshake in cycle N, ram_oe_o in N, ram_rvalid_i in N+1, rsp_valid_o in N+2. Latency 2, throughput 1 read per cycle.
- full_o and count_o are registered.
- req_ready_o, wr_ready_o and the ram_* controls are combinational from state and inputs.
- State transitions take effect on the edge after the triggering pulse.

## Configuration
- VALUE_RAM_CTRL_BOUNDS_CHECK_EN defined:
  - A granted request with addr >= count_o issues no RAM read (ram_oe_o=0).
  - Two cycles later it returns rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0, with the correct rsp_id_o.
  - The grant still advances rr_ptr.
- VALUE_RAM_CTRL_BOUNDS_CHECK_EN undefined:
  - Every grant issues a RAM read and rsp_err_o is tied 0.
  - Out-of-range addresses return stale RAM contents.

## Test plan
- Reset, then write 3 values (0xA, 0xB, 0xC) and pulse msg_end -> RAM addresses 0..2 hold A/B/C, count_o=3, state READ, wr_ready_o=0.
- Both requesters hold valid continuously with addr 0 and addr 2 for 4 cycles -> grants alternate 0,1,0,1. Responses arrive 2 cycles after each grant with data A,C,A,C and ids 0,1,0,1.
- Write 33 values with wr_valid_i held high -> 32 accepted, full_o=1, wr_ready_o=0 after the 32nd, overflow_o=1. A subsequent msg_release clears count_o and overflow_o.
- In READ, grant a read and pulse msg_release in the next cycle -> the in-flight response is still delivered, DRAIN lasts 2 cycles, then FILL with count_o=0 and the next write lands at address 0.
- With VALUE_RAM_CTRL_BOUNDS_CHECK_EN and count_o=3, requester 1 reads addr 7 -> ram_oe_o=0, and two cycles later rsp_valid_o=1, rsp_err_o=1, rsp_id_o=1, rsp_data_o=0.
- Assert rst in the cycle after a grant -> rsp_valid_o stays 0, count_o=0, state FILL.
